fbuff_writer: RTL and testbench
===============================

# fbuff_writer

Write-side packer for the tiled frame buffer. It accepts a stream of tile-colour pixels, one pixel per tile in raster tile order. It packs `TILE_PER_ROW` consecutive pixels into one frame-buffer word and writes each word to the frame buffer's write port (`addra`/`dina`/`wea`) through a request/grant handshake. It is the producer counterpart of the line-buffer read path: words it writes at address A are the words the line buffers later fetch from address A.

## Interface
- `PXL_WIDTH`, 12: bits per pixel (4 bits each of R, G, B).
- `TILE_PER_ROW`, 4: pixels packed per frame-buffer word.
- `FBUFF_DATA_WIDTH`, 48: word width; must equal `TILE_PER_ROW*PXL_WIDTH`.
- `FBUFF_DEPTH`, 4800: words per frame.
- `FBUFF_ADDR_WIDTH`, 13: address width, `$clog2(FBUFF_DEPTH-1)`.

Ports:
- `clk_i` in 1: system clock; single clock domain.
- `rst_i` in 1: reset; synchronous, active-high.
- `pxl_i` in `PXL_WIDTH`: incoming tile pixel.
- `pxl_valid_i` in 1: `pxl_i`/`sof_i` valid.
- `sof_i` in 1: qualifies the first pixel of a frame.
- `pxl_ready_o` out 1: pixel accepted when `pxl_valid_i & pxl_ready_o`.
- `addra_o` out `FBUFF_ADDR_WIDTH`: write address.
- `dina_o` out `FBUFF_DATA_WIDTH`: write data.
- `wea_o` out 1: write request; address and data are held stable while high.
- `wr_gnt_i` in 1: write performed in any cycle where `wea_o & wr_gnt_i`.
- `frame_done_o` out 1: one-cycle pulse after the last word of a frame is written.
- `resync_o` out 1: one-cycle pulse when `sof_i` arrives mid-frame.

## Operation

**Datapath**
- Pack register holds up to `TILE_PER_ROW-1` pixels.
- Slot counter `slot` runs 0..`TILE_PER_ROW-1`.
- Pixel k of a word occupies `dina[k*PXL_WIDTH +: PXL_WIDTH]`; the first-accepted pixel is in the LSBs.
- Output register holds `addra_o`/`dina_o` and a valid flag; `wea_o` equals that flag.

**State machine**
- IDLE:
  - `pxl_ready_o`=1.
  - Accepted pixels without `sof_i` are dropped.
  - An accepted pixel with `sof_i` goes to slot 0, sets word address to 0, and moves to FILL.
- FILL:
  - Each accepted pixel goes to slot `slot`, and `slot` increments.
  - On accepting slot `TILE_PER_ROW-1`, the full word and the current word address load into the output register, `slot` returns to 0, and the word address increments.
  - After loading address `FBUFF_DEPTH-1`, the state returns to IDLE.
  - The word address wraps to 0.

**Backpressure**
- `pxl_ready_o`=0 only when `slot==TILE_PER_ROW-1`, the output register is valid, and `wr_gnt_i`=0.
- Otherwise `pxl_ready_o`=1.
- A grant in the same cycle frees the output register for the completing word.
- There is no combinational path from `pxl_valid_i` to `pxl_ready_o`.

**Write handshake**
- The output register clears on `wea_o & wr_gnt_i` unless reloaded in the same cycle.
- `wr_gnt_i` while `wea_o`=0 is ignored.

**frame_done_o**
- Pulses the cycle after the write of address `FBUFF_DEPTH-1` is granted.

**Mid-frame SOF** (in FILL, an accepted pixel with `sof_i`)
- The partial pack is discarded.
- Any pending output word is still written at its latched address.
- The SOF pixel becomes slot 0 of address 0.
- `resync_o` pulses next cycle.
- No `frame_done_o` is produced for the aborted frame.
- SOF coinciding with a word-completing slot: SOF wins, and the partial word is discarded.

**Reset**
- `rst_i` forces IDLE, slot 0, address 0, and output register invalid.
- Outputs: `wea_o`=0, `addra_o`=0, `dina_o`=0, `frame_done_o`=0, `resync_o`=0, `pxl_ready_o`=1 (from the first cycle after reset).
- A pending un-granted word is lost.

## Timing
- Latency: the last pixel of a word accepted at edge N gives `wea_o`=1 with that word after edge N.
- A write completes at the first edge with `wr_gnt_i`=1.
- Sustained throughput with `wr_gnt_i` tied high: 1 pixel/cycle, 1 write per `TILE_PER_ROW` cycles.
- `frame_done_o` occurs 1 cycle after the final granted write.
- `resync_o` occurs 1 cycle after the accepting edge.
- All outputs are registered except `pxl_ready_o`, which depends combinationally on `wr_gnt_i`.

## Test plan
- **Reset, then one full frame:**
  - Stimulus: `wr_gnt_i`=1; stream 19200 pixels, value = index mod 4096, `sof_i` on pixel 0.
  - Expect 4800 writes at addresses 0..4799.
  - Address 0 data = 0x003_002_001_000.
  - `frame_done_o` fires exactly once, then IDLE.
- **Pre-SOF junk:** 5 pixels without `sof_i`, then a SOF frame. Expect no writes until the fourth pixel after SOF; the first write is at address 0.
- **Grant stall:**
  - Stimulus: `wr_gnt_i`=0 for 10 cycles after the first word.
  - Expect `pxl_ready_o`=0 once slot 3 is reached with the output pending.
  - Expect `addra_o`=0 and `dina_o` stable throughout.
  - On grant: write at address 0, and the pending pixel is accepted that cycle.
- **Mid-frame SOF:**
  - Stimulus: SOF on pixel 10 of a frame.
  - Expect the word at address 1 to be written, pixels 8–9 to be discarded, and `resync_o` to pulse.
  - The next write is at address 0 containing the SOF pixel in the LSBs.
- **Reset mid-operation:**
  - Stimulus: assert `rst_i` with `wea_o`=1 and slot 2.
  - Expect `wea_o`=0 the next cycle, no write, and IDLE.
  - A following SOF frame writes from address 0.
- **Back-to-back frames:** the SOF of frame 2 arrives the cycle after the last pixel of frame 1. Expect `frame_done_o` for frame 1, no `resync_o`, and frame 2 starting at address 0.

Source files
------------

// File: rtl/fbuff_writer_if.sv
// Pixel-stream input and frame-buffer write-port bundle for fbuff_writer.
// slave is the packer's view; master is the producer/frame-buffer view.
interface fbuff_writer_if #(
    parameter int PXL_WIDTH        = 12,
    parameter int FBUFF_DATA_WIDTH = 48,
    parameter int FBUFF_ADDR_WIDTH = 13
);
    logic [PXL_WIDTH-1:0]        pxl_i;
    logic                        pxl_valid_i;
    logic                        sof_i;
    logic                        pxl_ready_o;
    logic [FBUFF_ADDR_WIDTH-1:0] addra_o;
    logic [FBUFF_DATA_WIDTH-1:0] dina_o;
    logic                        wea_o;
    logic                        wr_gnt_i;
    logic                        frame_done_o;
    logic                        resync_o;

    modport slave (
        input  pxl_i, pxl_valid_i, sof_i, wr_gnt_i,
        output pxl_ready_o, addra_o, dina_o, wea_o, frame_done_o, resync_o
    );

    modport master (
        output pxl_i, pxl_valid_i, sof_i, wr_gnt_i,
        input  pxl_ready_o, addra_o, dina_o, wea_o, frame_done_o, resync_o
    );
endinterface

// File: rtl/fbuff_writer.sv
// Packs TILE_PER_ROW tile pixels per frame-buffer word and writes each word
// through a request/grant port; words land at the addresses the line buffers read.
module fbuff_writer #(
    parameter int PXL_WIDTH        = 12,
    parameter int TILE_PER_ROW     = 4,
    parameter int FBUFF_DATA_WIDTH = 48,
    parameter int FBUFF_DEPTH      = 4800,
    parameter int FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH-1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fbuff_writer_if.slave fb
);
    localparam int SLOT_W = (TILE_PER_ROW > 2) ? $clog2(TILE_PER_ROW) : 1;
    localparam int PACK_W = (TILE_PER_ROW - 1) * PXL_WIDTH;
    localparam logic [SLOT_W-1:0]           SLOT_LAST = SLOT_W'(TILE_PER_ROW - 1);
    localparam logic [FBUFF_ADDR_WIDTH-1:0] ADDR_LAST = FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1);

    generate
        if (FBUFF_DATA_WIDTH != TILE_PER_ROW * PXL_WIDTH) begin : g_bad_width
            $error("fbuff_writer: FBUFF_DATA_WIDTH must equal TILE_PER_ROW*PXL_WIDTH");
        end
        if (TILE_PER_ROW < 2) begin : g_bad_tiles
            $error("fbuff_writer: TILE_PER_ROW must be at least 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    state_e                      state_q,      state_d;
    logic [SLOT_W-1:0]           slot_q,       slot_d;
    logic [PACK_W-1:0]           pack_q,       pack_d;
    logic [FBUFF_ADDR_WIDTH-1:0] waddr_q,      waddr_d;
    logic                        out_vld_q,    out_vld_d;
    logic                        out_last_q,   out_last_d;
    logic [FBUFF_ADDR_WIDTH-1:0] out_addr_q,   out_addr_d;
    logic [FBUFF_DATA_WIDTH-1:0] out_data_q,   out_data_d;
    logic                        frame_done_q, frame_done_d;
    logic                        resync_q,     resync_d;

    logic pxl_ready;
    logic accept;
    logic wr_fire;

    // Only a word-completing pixel needs the output register; a same-cycle
    // grant frees it, so ready depends on wr_gnt_i but never on pxl_valid_i.
    assign pxl_ready = !((slot_q == SLOT_LAST) && out_vld_q && !fb.wr_gnt_i);
    assign accept    = fb.pxl_valid_i && pxl_ready;
    assign wr_fire   = out_vld_q && fb.wr_gnt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            pack_q       <= '0;
            waddr_q      <= '0;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            resync_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            pack_q       <= pack_d;
            waddr_q      <= waddr_d;
            out_vld_q    <= out_vld_d;
            out_last_q   <= out_last_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
            resync_q     <= resync_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        pack_d       = pack_q;
        waddr_d      = waddr_q;
        out_vld_d    = out_vld_q && !wr_fire;
        out_last_d   = out_last_q && !wr_fire;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        frame_done_d = wr_fire && out_last_q;
        resync_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && fb.sof_i) begin
                    pack_d                = '0;
                    pack_d[PXL_WIDTH-1:0] = fb.pxl_i;
                    slot_d                = SLOT_W'(1);
                    waddr_d               = '0;
                    state_d               = ST_FILL;
                end
            end

            ST_FILL: begin
                if (accept) begin
                    if (fb.sof_i) begin
                        // Restart the frame; a word already in the output register still gets written.
                        pack_d                = '0;
                        pack_d[PXL_WIDTH-1:0] = fb.pxl_i;
                        slot_d                = SLOT_W'(1);
                        waddr_d               = '0;
                        resync_d              = 1'b1;
                    end else if (slot_q == SLOT_LAST) begin
                        out_vld_d  = 1'b1;
                        out_last_d = (waddr_q == ADDR_LAST);
                        out_addr_d = waddr_q;
                        out_data_d = {fb.pxl_i, pack_q};
                        slot_d     = '0;
                        if (waddr_q == ADDR_LAST) begin
                            waddr_d = '0;
                            state_d = ST_IDLE;
                        end else begin
                            waddr_d = waddr_q + FBUFF_ADDR_WIDTH'(1);
                        end
                    end else begin
                        for (int k = 0; k < TILE_PER_ROW - 1; k++) begin
                            if (slot_q == SLOT_W'(k)) begin
                                pack_d[k*PXL_WIDTH +: PXL_WIDTH] = fb.pxl_i;
                            end
                        end
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fb.pxl_ready_o  = pxl_ready;
    assign fb.wea_o        = out_vld_q;
    assign fb.addra_o      = out_addr_q;
    assign fb.dina_o       = out_data_q;
    assign fb.frame_done_o = frame_done_q;
    assign fb.resync_o     = resync_q;
endmodule

// File: tb/tb_fbuff_writer.sv
// Scoreboard bench for fbuff_writer: the driver pushes expected writes, a
// negedge monitor pops and compares each granted write.
module tb_fbuff_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    fbuff_writer_if #(.PXL_WIDTH(12), .FBUFF_DATA_WIDTH(48), .FBUFF_ADDR_WIDTH(13)) fbif ();

    fbuff_writer #(
        .PXL_WIDTH(12), .TILE_PER_ROW(4), .FBUFF_DATA_WIDTH(48),
        .FBUFF_DEPTH(4800), .FBUFF_ADDR_WIDTH(13)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .fb   (fbif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard and logs
    logic [12:0] exp_addr[$];
    logic [47:0] exp_data[$];
    logic [12:0] log_addr[$];
    logic [47:0] log_data[$];
    int fd_cnt = 0, rs_cnt = 0;
    int last_fire_cyc = -100, a0_fire_cyc = -100;
    int sof_acc_cyc = -100, acc_cyc = -100;

    // reference packer state
    bit          m_active = 0;
    int          m_slot = 0;
    int          m_addr = 0;
    logic [47:0] m_pack = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input logic [11:0] pix, input logic s);
        if (s) begin
            m_active = 1;
            m_slot   = 0;
            m_addr   = 0;
            m_pack   = '0;
        end
        if (m_active) begin
            m_pack[m_slot*12 +: 12] = pix;
            if (m_slot == 3) begin
                exp_addr.push_back(13'(m_addr));
                exp_data.push_back(m_pack);
                m_slot = 0;
                m_pack = '0;
                if (m_addr == 4799) begin
                    m_addr   = 0;
                    m_active = 0;
                end else begin
                    m_addr++;
                end
            end else begin
                m_slot++;
            end
        end
    endtask

    task automatic send_pixel(input logic [11:0] pix, input logic s);
        bit done = 0;
        fbif.pxl_i       = pix;
        fbif.sof_i       = s;
        fbif.pxl_valid_i = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            if (fbif.pxl_ready_o) begin
                model_accept(pix, s);
                acc_cyc = cyc;
                if (s) sof_acc_cyc = cyc;
                done = 1;
            end
        end
        if (!done) chk("pixel_accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        fbif.pxl_valid_i = 1'b0;
        fbif.sof_i       = 1'b0;
    endtask

    task automatic clear_sb();
        exp_addr.delete();
        exp_data.delete();
        log_addr.delete();
        log_data.delete();
        fd_cnt = 0;
        rs_cnt = 0;
        m_active = 0;
        m_slot = 0;
        m_addr = 0;
        m_pack = '0;
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        fbif.pxl_valid_i = 1'b0;
        fbif.sof_i = 1'b0;
        clear_sb();
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 64 && exp_addr.size() != 0; t++) @(negedge clk);
        chk("drain_pending_writes", 64'(exp_addr.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (fbif.wea_o && fbif.wr_gnt_i) begin
                log_addr.push_back(fbif.addra_o);
                log_data.push_back(fbif.dina_o);
                if (fbif.addra_o == 13'd4799) last_fire_cyc = cyc;
                if (fbif.addra_o == 13'd0) a0_fire_cyc = cyc;
                if (exp_addr.size() == 0) begin
                    chk("unexpected_write", 64'(fbif.addra_o), 64'h1_0000);
                end else begin
                    chk("wr_addr", 64'(fbif.addra_o), 64'(exp_addr.pop_front()));
                    chk("wr_data", 64'(fbif.dina_o), 64'(exp_data.pop_front()));
                end
            end
            if (fbif.frame_done_o) begin
                fd_cnt++;
                chk("frame_done_latency", 64'(cyc), 64'(last_fire_cyc + 1));
            end
            if (fbif.resync_o) begin
                rs_cnt++;
                chk("resync_latency", 64'(cyc), 64'(sof_acc_cyc + 1));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        fbif.pxl_i = '0;
        fbif.pxl_valid_i = 1'b0;
        fbif.sof_i = 1'b0;
        fbif.wr_gnt_i = 1'b1;
        do_reset(3);

        // reset state
        @(negedge clk);
        chk("rst_wea", 64'(fbif.wea_o), 64'(0));
        chk("rst_addra", 64'(fbif.addra_o), 64'(0));
        chk("rst_dina", 64'(fbif.dina_o), 64'(0));
        chk("rst_frame_done", 64'(fbif.frame_done_o), 64'(0));
        chk("rst_resync", 64'(fbif.resync_o), 64'(0));
        chk("rst_ready", 64'(fbif.pxl_ready_o), 64'(1));
        @(posedge clk); #1;

        // full frame then back-to-back frame 2
        for (int i = 0; i < 19200; i++) send_pixel(12'(i % 4096), i == 0);
        for (int i = 0; i < 8; i++) send_pixel(12'h7E0 + 12'(i), i == 0);
        wait_drain();
        chk("frame1_done_count", 64'(fd_cnt), 64'(1));
        chk("frame1_no_resync", 64'(rs_cnt), 64'(0));
        chk("frame1_write_count", 64'(log_addr.size()), 64'(4802));
        if (log_addr.size() == 4802) begin
            chk("frame1_addr0", 64'(log_addr[0]), 64'(0));
            chk("frame1_data0", 64'(log_data[0]), 64'h003002001000);
            chk("frame1_addr_last", 64'(log_addr[4799]), 64'(4799));
            chk("frame1_data_last", 64'(log_data[4799]), 64'hAFFAFEAFDAFC);
            chk("frame2_addr0", 64'(log_addr[4800]), 64'(0));
            chk("frame2_data0", 64'(log_data[4800]), 64'h7E37E27E17E0);
        end

        // pre-SOF junk
        do_reset(2);
        for (int i = 0; i < 5; i++) send_pixel(12'hF00 + 12'(i), 1'b0);
        send_pixel(12'h111, 1'b1);
        send_pixel(12'h222, 1'b0);
        send_pixel(12'h333, 1'b0);
        repeat (3) @(negedge clk);
        chk("junk_no_early_write", 64'(log_addr.size()), 64'(0));
        @(posedge clk); #1;
        send_pixel(12'h444, 1'b0);
        wait_drain();
        chk("junk_write_count", 64'(log_addr.size()), 64'(1));
        if (log_addr.size() == 1) begin
            chk("junk_addr0", 64'(log_addr[0]), 64'(0));
            chk("junk_data0", 64'(log_data[0]), 64'h444333222111);
        end

        // grant stall
        do_reset(2);
        fbif.wr_gnt_i = 1'b0;
        for (int i = 0; i < 7; i++) send_pixel(12'h010 + 12'(i), i == 0);
        fork
            send_pixel(12'h017, 1'b0);
            begin
                for (int t = 0; t < 10; t++) begin
                    @(negedge clk);
                    chk("stall_ready", 64'(fbif.pxl_ready_o), 64'(0));
                    chk("stall_wea", 64'(fbif.wea_o), 64'(1));
                    chk("stall_addra", 64'(fbif.addra_o), 64'(0));
                    chk("stall_dina", 64'(fbif.dina_o), 64'h013012011010);
                end
                @(posedge clk); #1;
                fbif.wr_gnt_i = 1'b1;
            end
        join
        chk("stall_accept_with_grant", 64'(acc_cyc), 64'(a0_fire_cyc));
        wait_drain();
        chk("stall_write_count", 64'(log_addr.size()), 64'(2));
        if (log_addr.size() == 2) begin
            chk("stall_addr1", 64'(log_addr[1]), 64'(1));
            chk("stall_data1", 64'(log_data[1]), 64'h017016015014);
        end

        // mid-frame SOF on pixel 10
        do_reset(2);
        for (int i = 0; i < 10; i++) send_pixel(12'h100 + 12'(i), i == 0);
        send_pixel(12'h5A5, 1'b1);
        send_pixel(12'h5A6, 1'b0);
        send_pixel(12'h5A7, 1'b0);
        send_pixel(12'h5A8, 1'b0);
        wait_drain();
        chk("resync_count", 64'(rs_cnt), 64'(1));
        chk("resync_no_frame_done", 64'(fd_cnt), 64'(0));
        chk("resync_write_count", 64'(log_addr.size()), 64'(3));
        if (log_addr.size() == 3) begin
            chk("resync_addr1", 64'(log_addr[1]), 64'(1));
            chk("resync_data1", 64'(log_data[1]), 64'h107106105104);
            chk("resync_addr_restart", 64'(log_addr[2]), 64'(0));
            chk("resync_data_restart", 64'(log_data[2]), 64'h5A85A75A65A5);
        end

        // reset mid-operation with a pending word and slot 2
        do_reset(2);
        fbif.wr_gnt_i = 1'b0;
        for (int i = 0; i < 6; i++) send_pixel(12'h200 + 12'(i), i == 0);
        @(negedge clk);
        chk("midrst_wea_before", 64'(fbif.wea_o), 64'(1));
        @(posedge clk); #1;
        do_reset(1);
        @(negedge clk);
        chk("midrst_wea_after", 64'(fbif.wea_o), 64'(0));
        chk("midrst_ready_after", 64'(fbif.pxl_ready_o), 64'(1));
        fbif.wr_gnt_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_write", 64'(log_addr.size()), 64'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_pixel(12'h300 + 12'(i), i == 0);
        wait_drain();
        chk("midrst_write_count", 64'(log_addr.size()), 64'(1));
        if (log_addr.size() == 1) begin
            chk("midrst_addr0", 64'(log_addr[0]), 64'(0));
            chk("midrst_data0", 64'(log_data[0]), 64'h303302301300);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
